pe_mem_sched: RTL

- Frame-level sequencer for one LDPC processing element's memory block (3 extrinsic RAMs, 2-bank intrinsic RAM, 2-bank decision RAM, shared address).
- Drives the shared address and all chip-select, write-enable and bank-select lines through four phases:
  - intrinsic LOAD
  - check-node (CN) sweeps and variable-node (VN) sweeps, repeated per iteration
  - decision UNLOAD
- Bank used by each frame toggles frame-to-frame (ping-pong).

---
 rtl/pe_mem_sched_if.sv | 39 +++
 rtl/pe_mem_sched.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pe_mem_sched_if.sv
// Control bundle between the PE memory-block sequencer and its frame-level environment.
// The sequencer connects to the slave modport; the frame source connects to the master modport.
interface pe_mem_sched_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int ITER_WIDTH = 4
);
  logic                  start;
  logic [ITER_WIDTH-1:0] max_iter;
  logic                  syndrome_ok;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] address;
  logic                  ext_we;
  logic                  ext_cs;
  logic [1:0]            int_we;
  logic [1:0]            int_cs;
  logic                  int_rs;
  logic [1:0]            dec_we;
  logic [1:0]            dec_cs;
  logic                  dec_rs;
  logic                  pe_phase;
  logic                  out_valid;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic [ITER_WIDTH-1:0] iter_cnt;

  modport master (
    output start, max_iter, syndrome_ok, in_valid,
    input  in_ready, address, ext_we, ext_cs, int_we, int_cs, int_rs,
           dec_we, dec_cs, dec_rs, pe_phase, out_valid, out_last, busy, done, iter_cnt
  );

  modport slave (
    input  start, max_iter, syndrome_ok, in_valid,
    output in_ready, address, ext_we, ext_cs, int_we, int_cs, int_rs,
           dec_we, dec_cs, dec_rs, pe_phase, out_valid, out_last, busy, done, iter_cnt
  );
endinterface

// File: rtl/pe_mem_sched.sv
// Frame sequencer for one LDPC PE memory block: LOAD, CN/VN sweeps per iteration, UNLOAD.
// Intrinsic and decision RAMs ping-pong between two banks on alternate frames.
module pe_mem_sched #(
  parameter int ADDR_WIDTH = 8,
  parameter int FRAME_LEN  = 256,
  parameter int ITER_WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  pe_mem_sched_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

  // TAIL is the extra cycle that carries the last read word out of the RAM.
  typedef enum logic [2:0] {IDLE, LOAD, CN, VN, UNLOAD, TAIL} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic                  w_q, w_d;
  logic                  bank_q, bank_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [ITER_WIDTH-1:0] limit_q, limit_d;

  logic       in_ready_q, in_ready_d;
  logic       ext_cs_q, ext_cs_d;
  logic       ext_we_q, ext_we_d;
  logic       pe_phase_q, pe_phase_d;
  logic [1:0] int_cs_q, int_cs_d;
  logic       int_rs_q, int_rs_d;
  logic [1:0] dec_cs_q, dec_cs_d;
  logic [1:0] dec_we_q, dec_we_d;
  logic       dec_rs_q, dec_rs_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       beat;
  logic       sweep_end;
  logic [1:0] load_we;

  assign beat      = bus.in_valid & in_ready_q;
  assign sweep_end = w_q & (a_q == LAST_ADDR);

  always_comb begin : next_state
    // NOTE: every variable gets a default first so no latch is inferred on untaken branches.
    state_d = state_q;
    a_d     = a_q;
    w_d     = w_q;
    bank_d  = bank_q;
    iter_d  = iter_q;
    limit_d = limit_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          a_d     = '0;
          w_d     = 1'b0;
          iter_d  = '0;
          limit_d = (bus.max_iter == '0) ? ITER_WIDTH'(1) : bus.max_iter;
        end
      end
      LOAD: begin
        if (beat) begin
          if (a_q == LAST_ADDR) begin
            state_d = CN;
            a_d     = '0;
          end else begin
            a_d = a_q + 1'b1;
          end
        end
      end
      CN, VN: begin
        w_d = ~w_q;
        if (w_q) a_d = sweep_end ? '0 : a_q + 1'b1;
        if (sweep_end) begin
          if (state_q == CN) begin
            state_d = VN;
          end else begin
            iter_d  = iter_q + 1'b1;
            state_d = (bus.syndrome_ok || (iter_d == limit_q)) ? UNLOAD : CN;
          end
        end
      end
      UNLOAD: begin
        if (a_q == LAST_ADDR) state_d = TAIL;
        else                  a_d     = a_q + 1'b1;
      end
      TAIL: begin
        state_d = IDLE;
        a_d     = '0;
        bank_d  = ~bank_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes for the coming cycle are decoded from the next state so they leave the block from flops.
  always_comb begin : next_outputs
    in_ready_d  = (state_d == LOAD);
    ext_cs_d    = (state_d == CN) || (state_d == VN);
    ext_we_d    = ext_cs_d & w_d;
    pe_phase_d  = (state_d == VN);
    int_cs_d    = '0;
    dec_cs_d    = '0;
    dec_we_d    = '0;
    int_cs_d[bank_d] = pe_phase_d;
    dec_we_d[bank_d] = pe_phase_d & w_d;
    dec_cs_d[bank_d] = (pe_phase_d & w_d) | (state_d == UNLOAD);
    int_rs_d    = pe_phase_d & bank_d;
    dec_rs_d    = ((state_d == UNLOAD) || (state_d == TAIL)) & bank_d;
    out_valid_d = ((state_d == UNLOAD) && (a_d != '0)) || (state_d == TAIL);
    out_last_d  = (state_d == TAIL);
    busy_d      = (state_d != IDLE);
    done_d      = (state_q == TAIL);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      w_q         <= 1'b0;
      bank_q      <= 1'b0;
      iter_q      <= '0;
      limit_q     <= '0;
      in_ready_q  <= 1'b0;
      ext_cs_q    <= 1'b0;
      ext_we_q    <= 1'b0;
      pe_phase_q  <= 1'b0;
      int_cs_q    <= '0;
      int_rs_q    <= 1'b0;
      dec_cs_q    <= '0;
      dec_we_q    <= '0;
      dec_rs_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      w_q         <= w_d;
      bank_q      <= bank_d;
      iter_q      <= iter_d;
      limit_q     <= limit_d;
      in_ready_q  <= in_ready_d;
      ext_cs_q    <= ext_cs_d;
      ext_we_q    <= ext_we_d;
      pe_phase_q  <= pe_phase_d;
      int_cs_q    <= int_cs_d;
      int_rs_q    <= int_rs_d;
      dec_cs_q    <= dec_cs_d;
      dec_we_q    <= dec_we_d;
      dec_rs_q    <= dec_rs_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // A load write lands in the same cycle as its accepted beat, qualified by the registered in_ready.
  assign load_we = beat ? (bank_q ? 2'b10 : 2'b01) : 2'b00;

  assign bus.in_ready  = in_ready_q;
  assign bus.address   = a_q;
  assign bus.ext_cs    = ext_cs_q;
  assign bus.ext_we    = ext_we_q;
  assign bus.int_we    = load_we;
  assign bus.int_cs    = int_cs_q | load_we;
  assign bus.int_rs    = int_rs_q;
  assign bus.dec_we    = dec_we_q;
  assign bus.dec_cs    = dec_cs_q;
  assign bus.dec_rs    = dec_rs_q;
  assign bus.pe_phase  = pe_phase_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.iter_cnt  = iter_q;
endmodule
